// File: rtl/hier_node_pkg.sv
// Shared types and default sizing for the hierarchical node arbiter.
//   arb_mode_e     : arbitration policy selector (round-robin or fixed priority)
//   *_DEF          : default values for NUM_CH, DATA_W and FIFO_DEPTH
package hier_node_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   localparam int NUM_CH_DEF     = 5;
   localparam int DATA_W_DEF     = 16;
   localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/hier_node_fifo.sv
// Per-channel synchronous FIFO with wrap-around pointers and an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i     : write request, ignored while full
//   pop_i      : read request, ignored while empty
//   wdata_i    : write data
//   rdata_o    : head-of-queue data (valid while not empty)
//   full_o     : occupancy == DEPTH
//   empty_o    : occupancy == 0
module hier_node_fifo
   import hier_node_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q;
   logic [AW-1:0]     rptr_q;
   logic [AW:0]       cnt_q;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: a zero count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/hier_node_arb.sv
// Merges NUM_CH buffered child streams into one registered output stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-channel payload valid
//   in_data    : per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   in_ready   : per-channel accept (FIFO not full)
//   ch_en      : per-channel grant enable
//   out_valid  : merged payload valid
//   out_data   : merged payload
//   out_ch     : source channel of out_data
//   out_ready  : downstream accept
//   busy       : any FIFO non-empty or out_valid high
module hier_node_arb
   import hier_node_pkg::*;
#(
   parameter int        NUM_CH     = NUM_CH_DEF,
   parameter int        DATA_W     = DATA_W_DEF,
   parameter int        FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter arb_mode_e ARB_MODE   = ARB_RR,
   localparam int       IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH-1:0]        ch_en,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [IDX_W-1:0]         out_ch,
   input  logic                     out_ready,
   output logic                     busy
);

   logic [DATA_W-1:0] head [NUM_CH];
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] elig;
   logic              loadable;
   logic              gnt_any;
   logic [IDX_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] gnt_data;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [IDX_W-1:0]  out_ch_q;
   logic [IDX_W-1:0]  last_grant_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      hier_node_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push_i  (in_valid[g]),
         .pop_i   (pop[g]),
         .wdata_i (in_data[g*DATA_W +: DATA_W]),
         .rdata_o (head[g]),
         .full_o  (full[g]),
         .empty_o (empty[g])
      );
      assign pop[g] = loadable & gnt_any & (gnt_idx == IDX_W'(g));
   end

   assign in_ready = ~full;
   assign elig     = ~empty & ch_en;
   assign loadable = ~out_valid_q | out_ready;

   // Both searches walk from lowest to highest priority so the last hit wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (ARB_MODE == ARB_FIXED) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
               gnt_any = 1'b1;
               gnt_idx = IDX_W'(i);
            end
         end
      end else begin
         // Offset NUM_CH (last_grant itself) is lowest priority, offset 1 highest.
         for (int off = NUM_CH; off >= 1; off--) begin
            if (elig[(int'(last_grant_q) + off) % NUM_CH]) begin
               gnt_any = 1'b1;
               gnt_idx = IDX_W'((int'(last_grant_q) + off) % NUM_CH);
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_idx == IDX_W'(i)) gnt_data = head[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_ch_q     <= '0;
         last_grant_q <= IDX_W'(NUM_CH - 1);
      end else if (loadable) begin
         out_valid_q <= gnt_any;
         if (gnt_any) begin
            out_data_q   <= gnt_data;
            out_ch_q     <= gnt_idx;
            last_grant_q <= gnt_idx;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign busy      = out_valid_q | ~(&empty);

endmodule
